// File: rtl/ahb_lite_master_request_arbiter.sv
// Two-requester round-robin arbiter feeding the instr_* side of the AHB-lite
// master. Supports locked sequences, caps outstanding reads per requester and
// follows each beat through the master's 3-stage pipe so that read responses
// are returned only to the requester that issued them.
module ahb_lite_master_request_arbiter #(
  parameter int MAX_OUT = 2  // outstanding reads per requester, 1..3
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HREADY,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_lock,
  input  logic [31:0] req0_haddr,
  input  logic        req0_hwrite,
  input  logic [2:0]  req0_hsize,
  input  logic [31:0] req0_hwdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_lock,
  input  logic [31:0] req1_haddr,
  input  logic        req1_hwrite,
  input  logic [2:0]  req1_hsize,
  input  logic [31:0] req1_hwdata,
  output logic        instr_available,
  output logic [31:0] instr_haddr,
  output logic        instr_hwrite,
  output logic [2:0]  instr_hsize,
  output logic [31:0] instr_hwdata,
  input  logic        hrdata_ready,
  input  logic [31:0] rdata_in,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_rdata
);

  localparam logic [1:0] MAX_OUT_C = MAX_OUT[1:0];

  // Arbitration state
  logic       rr_ptr_q, rr_ptr_d;
  logic       lock_active_q, lock_active_d;
  logic       lock_owner_q, lock_owner_d;
  logic [1:0] cnt0_q, cnt0_d;
  logic [1:0] cnt1_q, cnt1_d;
  logic       hready_q, hready_d;

  // Ownership tags mirroring the master's address/data pipe
  logic tag_vld_p1_q, tag_vld_p1_d, tag_id_p1_q, tag_id_p1_d, tag_wr_p1_q, tag_wr_p1_d;
  logic tag_vld_p2_q, tag_vld_p2_d, tag_id_p2_q, tag_id_p2_d, tag_wr_p2_q, tag_wr_p2_d;
  logic tag_vld_p3_q, tag_vld_p3_d, tag_id_p3_q, tag_id_p3_d, tag_wr_p3_q, tag_wr_p3_d;

  logic elig0, elig1, grant0, grant1, acc0, acc1, accept;
  logic inc0, inc1;

  // Eligibility, round-robin grant and zero-cycle accept handshake
  always_comb begin
    elig0  = req0_valid & (req0_hwrite | (cnt0_q < MAX_OUT_C))
           & (~lock_active_q | ~lock_owner_q);
    elig1  = req1_valid & (req1_hwrite | (cnt1_q < MAX_OUT_C))
           & (~lock_active_q | lock_owner_q);
    grant0 = elig0 & (~elig1 | ~rr_ptr_q);
    grant1 = elig1 & (~elig0 | rr_ptr_q);
    acc0   = HREADY & grant0;
    acc1   = HREADY & grant1;
    accept = acc0 | acc1;
    inc0   = acc0 & ~req0_hwrite;
    inc1   = acc1 & ~req1_hwrite;
  end

  assign req0_ready      = acc0;
  assign req1_ready      = acc1;
  assign instr_available = accept;

  // Payload mux from the granted requester; zeros when nobody is granted
  always_comb begin
    instr_haddr  = 32'd0;
    instr_hwrite = 1'b0;
    instr_hsize  = 3'd0;
    instr_hwdata = 32'd0;
    if (grant0) begin
      instr_haddr  = req0_haddr;
      instr_hwrite = req0_hwrite;
      instr_hsize  = req0_hsize;
      instr_hwdata = req0_hwdata;
    end else if (grant1) begin
      instr_haddr  = req1_haddr;
      instr_hwrite = req1_hwrite;
      instr_hsize  = req1_hsize;
      instr_hwdata = req1_hwdata;
    end
  end

  // A read response belongs to the tag in the last stage; hready_q keeps a
  // frozen tail tag from pulsing again while the master stretches HREADY low.
  assign rsp0_valid = hrdata_ready & hready_q & tag_vld_p3_q & ~tag_wr_p3_q & ~tag_id_p3_q;
  assign rsp1_valid = hrdata_ready & hready_q & tag_vld_p3_q & ~tag_wr_p3_q &  tag_id_p3_q;
  assign rsp_rdata  = rdata_in;

  // Next-state for round-robin pointer, lock and outstanding-read counters
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
    hready_d      = HREADY;
    if (acc0) begin
      rr_ptr_d      = 1'b1;
      lock_active_d = req0_lock;
      lock_owner_d  = 1'b0;
    end else if (acc1) begin
      rr_ptr_d      = 1'b0;
      lock_active_d = req1_lock;
      lock_owner_d  = 1'b1;
    end
    cnt0_d = cnt0_q;
    case ({inc0, rsp0_valid})
      2'b10:   cnt0_d = cnt0_q + 2'd1;
      2'b01:   cnt0_d = cnt0_q - 2'd1;
      default: cnt0_d = cnt0_q;
    endcase
    cnt1_d = cnt1_q;
    case ({inc1, rsp1_valid})
      2'b10:   cnt1_d = cnt1_q + 2'd1;
      2'b01:   cnt1_d = cnt1_q - 2'd1;
      default: cnt1_d = cnt1_q;
    endcase
  end

  // Tag pipe advances only on HREADY, in step with the master's pipe
  always_comb begin
    tag_vld_p1_d = tag_vld_p1_q;
    tag_id_p1_d  = tag_id_p1_q;
    tag_wr_p1_d  = tag_wr_p1_q;
    tag_vld_p2_d = tag_vld_p2_q;
    tag_id_p2_d  = tag_id_p2_q;
    tag_wr_p2_d  = tag_wr_p2_q;
    tag_vld_p3_d = tag_vld_p3_q;
    tag_id_p3_d  = tag_id_p3_q;
    tag_wr_p3_d  = tag_wr_p3_q;
    if (HREADY) begin
      // stage 1: beat accepted this cycle
      tag_vld_p1_d = accept;
      tag_id_p1_d  = acc1;
      tag_wr_p1_d  = acc1 ? req1_hwrite : req0_hwrite;
      // stage 2
      tag_vld_p2_d = tag_vld_p1_q;
      tag_id_p2_d  = tag_id_p1_q;
      tag_wr_p2_d  = tag_wr_p1_q;
      // stage 3: data phase, response owner
      tag_vld_p3_d = tag_vld_p2_q;
      tag_id_p3_d  = tag_id_p2_q;
      tag_wr_p3_d  = tag_wr_p2_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rr_ptr_q      <= 1'b0;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      cnt0_q        <= 2'd0;
      cnt1_q        <= 2'd0;
      hready_q      <= 1'b0;
      tag_vld_p1_q  <= 1'b0;
      tag_id_p1_q   <= 1'b0;
      tag_wr_p1_q   <= 1'b0;
      tag_vld_p2_q  <= 1'b0;
      tag_id_p2_q   <= 1'b0;
      tag_wr_p2_q   <= 1'b0;
      tag_vld_p3_q  <= 1'b0;
      tag_id_p3_q   <= 1'b0;
      tag_wr_p3_q   <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      hready_q      <= hready_d;
      tag_vld_p1_q  <= tag_vld_p1_d;
      tag_id_p1_q   <= tag_id_p1_d;
      tag_wr_p1_q   <= tag_wr_p1_d;
      tag_vld_p2_q  <= tag_vld_p2_d;
      tag_id_p2_q   <= tag_id_p2_d;
      tag_wr_p2_q   <= tag_wr_p2_d;
      tag_vld_p3_q  <= tag_vld_p3_d;
      tag_id_p3_q   <= tag_id_p3_d;
      tag_wr_p3_q   <= tag_wr_p3_d;
    end
  end

  // Outstanding counters must never wrap in either direction
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      assert (!(inc0 && !rsp0_valid && cnt0_q == 2'd3));
      assert (!(rsp0_valid && !inc0 && cnt0_q == 2'd0));
      assert (!(inc1 && !rsp1_valid && cnt1_q == 2'd3));
      assert (!(rsp1_valid && !inc1 && cnt1_q == 2'd0));
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_request_arbiter.sv
// Testbench for ahb_lite_master_request_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_ahb_lite_master_request_arbiter;

  localparam int MAX_OUT = 2;

  logic        HCLK = 1'b0;
  logic        HRESET, HREADY;
  logic        v[2], lk[2], wr[2];
  logic [31:0] ad[2], wd[2];
  logic [2:0]  sz[2];
  logic        rdy0, rdy1, iav, ihw, rsp0, rsp1, hrdata_ready;
  logic [31:0] iad, iwd, rdata_in, rrd;
  logic [2:0]  isz;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master_request_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HREADY(HREADY),
    .req0_valid(v[0]), .req0_ready(rdy0), .req0_lock(lk[0]), .req0_haddr(ad[0]),
    .req0_hwrite(wr[0]), .req0_hsize(sz[0]), .req0_hwdata(wd[0]),
    .req1_valid(v[1]), .req1_ready(rdy1), .req1_lock(lk[1]), .req1_haddr(ad[1]),
    .req1_hwrite(wr[1]), .req1_hsize(sz[1]), .req1_hwdata(wd[1]),
    .instr_available(iav), .instr_haddr(iad), .instr_hwrite(ihw),
    .instr_hsize(isz), .instr_hwdata(iwd),
    .hrdata_ready(hrdata_ready), .rdata_in(rdata_in),
    .rsp0_valid(rsp0), .rsp1_valid(rsp1), .rsp_rdata(rrd)
  );

  // Reference model: each in-flight beat carries its owner and how many
  // HREADY-qualified edges it has seen; a read answers only in the first cycle
  // it sits in the data phase.
  typedef struct { bit id; bit w; int age; int held; } txn_t;
  txn_t pipe[$];
  bit   m_rr, m_lock_on, m_lock_who;
  int   m_out[2];

  task automatic model_reset();
    pipe.delete();
    m_rr = 0; m_lock_on = 0; m_lock_who = 0;
    m_out[0] = 0; m_out[1] = 0;
  endtask

  task automatic nxt();
    @(negedge HCLK);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; lk[i] = 0; wr[i] = 0; ad[i] = 0; wd[i] = 0; sz[i] = 0;
    end
    HREADY = 1; hrdata_ready = 0; rdata_in = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESET = 1;
    nxt(); nxt();
    HRESET = 0;
  endtask

  task automatic test_reset();
    logic [4:0]  got5;
    logic [67:0] gotp;
    do_reset();
    hrdata_ready = 1; rdata_in = $urandom;
    #1;
    got5 = {rdy0, rdy1, iav, rsp0, rsp1};
    checks++;
    if (got5 !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp %b", got5, 5'b0);
    end
    gotp = {iad, ihw, isz, iwd};
    checks++;
    if (gotp !== 68'd0) begin
      errors++; $display("FAIL reset_payload got %h exp 0", gotp);
    end
    checks++;
    if (rrd !== rdata_in) begin
      errors++; $display("FAIL reset_rdata got %h exp %h", rrd, rdata_in);
    end
    nxt();
    // grant exists without HREADY: payload follows requester 0, no accept
    HREADY = 0;
    v[0] = 1; ad[0] = 32'h0000_1111; v[1] = 1; ad[1] = 32'h0000_2222;
    #1;
    checks++;
    if ({rdy0, rdy1, iav} !== 3'b000 || iad !== 32'h0000_1111) begin
      errors++;
      $display("FAIL reset_first_prio got rdy=%b%b av=%b addr=%h exp 000 addr=00001111",
               rdy0, rdy1, iav, iad);
    end
    nxt();
  endtask

  task automatic test_alternate();
    logic [4:0] got, exp;
    int g;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      v[0] = 1; ad[0] = 32'hA000_0000; v[1] = 1; ad[1] = 32'hB000_0000;
      hrdata_ready = 1; rdata_in = $urandom;
      #1;
      g = c % 2;
      exp = {g == 0, g == 1, 1'b1, (c >= 3) && ((c - 3) % 2 == 0), (c >= 3) && ((c - 3) % 2 == 1)};
      got = {rdy0, rdy1, iav, rsp0, rsp1};
      checks++;
      if (got !== exp || iad !== ad[g] || rrd !== rdata_in) begin
        errors++;
        $display("FAIL alternate c%0d got %b addr %h rdata %h exp %b addr %h rdata %h",
                 c, got, iad, rrd, exp, ad[g], rdata_in);
      end
      nxt();
    end
  endtask

  task automatic test_max_out();
    logic [9:0] e_rdy, e_rsp;
    e_rdy = 10'b11_0011_0011;
    e_rsp = 10'b01_1001_1000;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      v[0] = 1; ad[0] = 32'h100 + c; hrdata_ready = 1;
      #1;
      checks++;
      if ({rdy0, rsp0, rdy1, rsp1} !== {e_rdy[c], e_rsp[c], 2'b00}) begin
        errors++;
        $display("FAIL max_out c%0d got rdy0=%b rsp0=%b rdy1=%b rsp1=%b exp rdy0=%b rsp0=%b",
                 c, rdy0, rsp0, rdy1, rsp1, e_rdy[c], e_rsp[c]);
      end
      nxt();
    end
  endtask

  task automatic test_lock();
    bit v0t[6], v1t[6], lkt[6], e0[6], e1[6];
    v0t = '{0, 1, 1, 1, 1, 1};
    v1t = '{1, 1, 0, 1, 0, 1};
    lkt = '{1, 1, 0, 0, 0, 0};
    e0  = '{0, 0, 0, 0, 1, 0};
    e1  = '{1, 1, 0, 1, 0, 1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      v[0] = v0t[c]; wr[0] = 0; ad[0] = 32'hC0C0_0000;
      v[1] = v1t[c]; wr[1] = 1; lk[1] = lkt[c]; ad[1] = 32'hD0D0_0000 + c; wd[1] = 32'h5555_0000 + c;
      #1;
      checks++;
      if ({rdy0, rdy1, iav} !== {e0[c], e1[c], e0[c] | e1[c]} ||
          iad !== (e0[c] ? ad[0] : (e1[c] ? ad[1] : 32'd0))) begin
        errors++;
        $display("FAIL lock c%0d got rdy=%b%b av=%b addr=%h exp rdy=%b%b", c, rdy0, rdy1, iav,
                 iad, e0[c], e1[c]);
      end
      nxt();
    end
  endtask

  task automatic test_hready_stall();
    logic [10:0] e_r0, e_r1, e_p0, e_p1;
    logic [3:0]  got, exp;
    e_r0 = 11'b101_0000_0101;
    e_r1 = 11'b010_0000_1010;
    e_p0 = 11'b010_0000_1000;
    e_p1 = 11'b100_0001_0000;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      v[0] = 1; ad[0] = 32'h0000_0A00; v[1] = 1; ad[1] = 32'h0000_0B00;
      HREADY = !(c >= 4 && c <= 7);
      hrdata_ready = 1; rdata_in = $urandom;
      #1;
      got = {rdy0, rdy1, rsp0, rsp1};
      exp = {e_r0[c], e_r1[c], e_p0[c], e_p1[c]};
      checks++;
      if (got !== exp || iav !== (e_r0[c] | e_r1[c])) begin
        errors++;
        $display("FAIL hready_stall c%0d got %b av=%b exp %b", c, got, iav, exp);
      end
      nxt();
    end
  endtask

  task automatic test_write_read();
    do_reset();
    v[0] = 1; wr[0] = 1; ad[0] = 32'h0000_4000; wd[0] = 32'hCAFE_F00D; sz[0] = 3'd2;
    v[1] = 1; wr[1] = 0; ad[1] = 32'h0000_5000; wd[1] = 32'h0BAD_0BAD; sz[1] = 3'd1;
    hrdata_ready = 1; rdata_in = 32'hDEADBEEF;
    #1;
    checks++;
    if ({rdy0, rdy1, ihw, isz, iwd, iad} !== {2'b10, 1'b1, 3'd2, 32'hCAFE_F00D, 32'h0000_4000}) begin
      errors++;
      $display("FAIL wr_accept got rdy=%b%b hw=%b sz=%0d wd=%h a=%h exp rdy=10 hw=1 sz=2 wd=cafef00d a=00004000",
               rdy0, rdy1, ihw, isz, iwd, iad);
    end
    nxt();
    v[0] = 0;
    #1;
    checks++;
    if ({rdy0, rdy1, ihw, isz, iwd} !== {2'b01, 1'b0, 3'd1, 32'h0BAD_0BAD}) begin
      errors++;
      $display("FAIL rd_accept got rdy=%b%b hw=%b sz=%0d wd=%h exp rdy=01 hw=0 sz=1 wd=0bad0bad",
               rdy0, rdy1, ihw, isz, iwd);
    end
    nxt();
    v[1] = 0;
    for (int c = 2; c < 8; c++) begin
      #1;
      checks++;
      if ({rsp0, rsp1} !== {1'b0, c == 4} || (c == 4 && rrd !== 32'hDEADBEEF)) begin
        errors++;
        $display("FAIL wr_rd_rsp c%0d got rsp=%b%b rdata=%h exp rsp=0%b rdata=deadbeef",
                 c, rsp0, rsp1, rrd, c == 4);
      end
      nxt();
    end
  endtask

  task automatic test_reset_inflight();
    bit v0t[4], v1t[4], e0[4], e1[4], p0[4];
    v0t = '{1, 1, 1, 1}; v1t = '{1, 1, 0, 0};
    e0  = '{1, 0, 1, 0}; e1  = '{0, 1, 0, 0};
    p0  = '{0, 0, 0, 1};
    do_reset();
    hrdata_ready = 1;
    v[0] = 1; v[1] = 1; ad[0] = 32'h10; ad[1] = 32'h20;
    #1;
    checks++;
    if ({rdy0, rdy1} !== 2'b10) begin
      errors++; $display("FAIL inflight_c0 got %b%b exp 10", rdy0, rdy1);
    end
    nxt();
    v[0] = 0;
    #1;
    checks++;
    if ({rdy0, rdy1} !== 2'b01) begin
      errors++; $display("FAIL inflight_c1 got %b%b exp 01", rdy0, rdy1);
    end
    nxt();
    v[1] = 0; HRESET = 1;
    nxt();
    HRESET = 0;
    for (int c = 3; c < 7; c++) begin
      #1;
      checks++;
      if ({rsp0, rsp1} !== 2'b00) begin
        errors++; $display("FAIL post_reset_rsp c%0d got %b%b exp 00", c, rsp0, rsp1);
      end
      nxt();
    end
    for (int c = 0; c < 4; c++) begin
      v[0] = v0t[c]; v[1] = v1t[c]; ad[0] = 32'h300 + c; ad[1] = 32'h400;
      #1;
      checks++;
      if ({rdy0, rdy1, rsp0, rsp1} !== {e0[c], e1[c], p0[c], 1'b0}) begin
        errors++;
        $display("FAIL post_reset_grant c%0d got %b%b%b%b exp %b%b%b0", c + 7, rdy0, rdy1, rsp0,
                 rsp1, e0[c], e1[c], p0[c]);
      end
      nxt();
    end
  endtask

  task automatic test_random();
    bit         took[2], el[2], acc;
    int         g;
    logic [1:0] e_rsp;
    logic [4:0] got, exp;
    logic [67:0] e_pl;
    txn_t        t;
    txn_t        nq[$];
    do_reset();
    model_reset();
    took[0] = 1; took[1] = 1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      HRESET       = ($urandom_range(0, 99) == 0);
      HREADY       = ($urandom_range(0, 9) < 8);
      hrdata_ready = ($urandom_range(0, 9) < 9);
      rdata_in     = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (!(v[i] && !took[i])) begin
          v[i]  = ($urandom_range(0, 9) < 6);
          lk[i] = ($urandom_range(0, 3) == 0);
          wr[i] = ($urandom_range(0, 9) < 3);
          ad[i] = $urandom; wd[i] = $urandom; sz[i] = 3'($urandom_range(0, 7));
        end
      end
      #1;
      for (int i = 0; i < 2; i++)
        el[i] = v[i] && (wr[i] || m_out[i] < MAX_OUT) && (!m_lock_on || m_lock_who == i);
      g = -1;
      if (el[0] && el[1]) g = int'(m_rr);
      else if (el[0]) g = 0;
      else if (el[1]) g = 1;
      acc = HREADY && (g >= 0);
      e_rsp = 2'b00;
      foreach (pipe[k])
        if (pipe[k].age == 3 && pipe[k].held == 0 && !pipe[k].w && hrdata_ready)
          e_rsp[pipe[k].id] = 1'b1;
      exp = {acc && g == 0, acc && g == 1, acc, e_rsp[0], e_rsp[1]};
      got = {rdy0, rdy1, iav, rsp0, rsp1};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rnd_ctrl cyc %0d got %b exp %b", cyc, got, exp);
      end
      e_pl = (g >= 0) ? {ad[g], wr[g], sz[g], wd[g]} : 68'd0;
      checks++;
      if ({iad, ihw, isz, iwd} !== e_pl) begin
        errors++; $display("FAIL rnd_payload cyc %0d got %h exp %h", cyc, {iad, ihw, isz, iwd}, e_pl);
      end
      checks++;
      if (rrd !== rdata_in) begin
        errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", cyc, rrd, rdata_in);
      end
      for (int i = 0; i < 2; i++) took[i] = acc && g == i;
      if (HRESET) begin
        model_reset();
      end else begin
        for (int i = 0; i < 2; i++)
          m_out[i] = m_out[i] + int'(acc && g == i && !wr[i]) - int'(e_rsp[i]);
        if (acc) begin
          m_rr = (g == 0); m_lock_on = lk[g]; m_lock_who = (g == 1);
        end
        if (HREADY) begin
          nq.delete();
          foreach (pipe[k])
            if (pipe[k].age < 3) begin
              t = pipe[k]; t.age++; nq.push_back(t);
            end
          if (acc) begin
            t.id = (g == 1); t.w = wr[g]; t.age = 1; t.held = 0;
            nq.push_back(t);
          end
          pipe = nq;
        end else begin
          foreach (pipe[k]) if (pipe[k].age == 3) pipe[k].held++;
        end
      end
      nxt();
    end
  endtask

  initial begin
    idle_inputs();
    HRESET = 1;
    nxt();
    test_reset();
    test_alternate();
    test_max_out();
    test_lock();
    test_hready_stall();
    test_write_read();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
